udma_i2c_slave: RTL
===================

UDMA_I2C_SLAVE -- requirements
Module: udma_i2c_slave

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (min 2).
REQ-002 SHALL have port: clk_i  in  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port: rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: cfg_en_i  in  1  target enable; low forces IDLE with SDA released.
REQ-005 SHALL have port: cfg_addr_i  in  7  own 7-bit bus address.
REQ-006 SHALL have ports: scl_i  in  1; sda_i  in  1  raw bus lines.
REQ-007 SHALL have ports: sda_o  out  1, constant 0; sda_oe  out  1, 1 = pull SDA low.
REQ-008 SHALL have ports: data_rx_o  out  8; data_rx_valid_o  out  1; data_rx_ready_i  in  1  bytes written by the bus master.
REQ-009 SHALL have ports: data_tx_i  in  8; data_tx_valid_i  in  1; data_tx_ready_o  out  1  bytes returned to the bus master.
REQ-010 SHALL have ports: busy_o  out  1 (addressed, START..STOP); addr_match_o, stop_o, nack_o, err_o  out  1 each, single-cycle pulses.

Function
REQ-011 SHALL synchronize scl_i/sda_i through SYNC_STAGES flops and detect edges against one further registered copy; all "SCL rise/fall" below refer to synchronized edges.
REQ-012 SHALL detect START as SDA fall while SCL high, STOP as SDA rise while SCL high; SDA changes while SCL high are never data.
REQ-013 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-014 START in any state (incl. repeated START) -> ADDR, bit counter cleared, sda_oe released; STOP in any state -> IDLE, sda_oe=0, stop_o pulse if busy_o was 1.
REQ-015 Data bits SHALL be shifted MSB first, sampled on SCL rise; a 3-bit counter wraps 7->0 at byte end.
REQ-016 ADDR: after 8th rise, if bits[7:1]==cfg_addr_i, latch R/W bit, pulse addr_match_o, set busy_o, and on next SCL fall assert sda_oe (ACK) -> ADDR_ACK; mismatch -> IGNORE with sda_oe never asserted.
REQ-017 ACK drive (any state) SHALL assert sda_oe on the SCL fall after the 8th bit and release it on the following SCL fall.
REQ-018 Write path: after 8th rise in WR_DATA, on next SCL fall, if data_rx_ready_i=1 assert data_rx_valid_o for exactly that cycle with the byte and ACK; else NACK (sda_oe=0), err_o pulse, -> IGNORE.
REQ-019 Read path: on the SCL fall ending the address ACK or a master ACK, load next byte: data_tx_valid_i=1 -> take data_tx_i, pulse data_tx_ready_o one cycle; else load 8'hFF and pulse err_o; drive MSB same cycle (sda_oe = ~bit).
REQ-020 RD_DATA SHALL update sda_oe on each SCL fall for bits 6..0, release SDA on the 8th fall, -> RD_ACK.
REQ-021 RD_ACK: SDA sampled 0 on SCL rise -> continue (REQ-019); sampled 1 -> pulse nack_o, -> IGNORE, SDA released.
REQ-022 IGNORE SHALL keep sda_oe=0 and leave only on START or STOP.
REQ-023 cfg_en_i low SHALL force IDLE within 1 cycle, clear busy_o, no pulses; rising cfg_en_i mid-transfer SHALL wait for next START.
REQ-024 data_rx_valid_o and data_tx_ready_o SHALL never be high outside REQ-018/REQ-019 cycles; no internal FIFO.

Reset
REQ-025 rst_i high SHALL force IDLE, synchronizers to 1 (idle bus), sda_oe=0, sda_o=0, data_rx_o=0, all valid/ready/event outputs 0, busy_o=0.
REQ-026 Reset mid-transfer SHALL release SDA immediately (asynchronously) and ignore the bus until next START.

Verification
REQ-027 cfg_addr_i=7'h42; master writes addr 0x84, data 0xA5, STOP, rx ready -> ACK on both bytes, data_rx_o=0xA5 with one valid pulse, addr_match_o and stop_o one pulse each.
REQ-028 Master writes addr 0x86 (mismatch) -> no ACK, sda_oe never 1, busy_o stays 0, no data pulses.
REQ-029 Read addr 0x85, tx supplies 0x3C then 0xC3, master ACK then NACK -> bus bits 00111100, 11000011, two data_tx_ready_o pulses, one nack_o pulse, IGNORE until STOP.
REQ-030 Write with data_rx_ready_i=0 at byte end -> NACK, err_o pulse, further bytes ignored; read with data_tx_valid_i=0 -> 0xFF on bus, err_o pulse.
REQ-031 Repeated START after write byte then read addr 0x85 -> ADDR re-entered, second addr_match_o, read proceeds; rst_i asserted during ACK low -> sda_oe=0 same cycle, idle until next START.

Source files
------------

// File: rtl/udma_i2c_slave.sv
// I2C target: 7-bit address, byte write/read streaming.
// SCL/SDA are synchronized; SDA is open-drain via sda_oe.
module udma_i2c_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_en_i,
  input  logic [6:0] cfg_addr_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic [7:0] data_rx_o,
  output logic       data_rx_valid_o,
  input  logic       data_rx_ready_i,
  input  logic [7:0] data_tx_i,
  input  logic       data_tx_valid_i,
  output logic       data_tx_ready_o,
  output logic       busy_o,
  output logic       addr_match_o,
  output logic       stop_o,
  output logic       nack_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA,
    WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       rw_q, rw_d;
  logic       pend_q, pend_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       rxv_q, rxv_d;
  logic       txr_q, txr_d;
  logic       match_q, match_d;
  logic       stop_q, stop_d;
  logic       nack_q, nack_d;
  logic       err_q, err_d;
  logic       do_load;
  logic [7:0] ld_byte;
  logic [7:0] rx_byte;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign ld_byte = data_tx_valid_i ? data_tx_i : 8'hFF;
  assign rx_byte = {sh_q[6:0], sda_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    pend_d  = pend_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rxv_d   = 1'b0;
    txr_d   = 1'b0;
    match_d = 1'b0;
    stop_d  = 1'b0;
    nack_d  = 1'b0;
    err_d   = 1'b0;
    do_load = 1'b0;
    if (!cfg_en_i) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = 3'd0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      stop_d  = busy_q;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = 3'd0;
    end else if (start_det) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: oe_d = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (sh_q[6:0] == cfg_addr_i) begin
                rw_d    = sda_s;
                match_d = 1'b1;
                busy_d  = 1'b1;
                pend_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end else if (scl_fall && pend_q) begin
            pend_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              do_load = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) pend_d = 1'b1;
          end else if (scl_fall && pend_q) begin
            pend_d = 1'b0;
            if (data_rx_ready_i) begin
              rx_d    = sh_q;
              rxv_d   = 1'b1;
              oe_d    = 1'b1;
              state_d = WR_ACK;
            end else begin
              err_d   = 1'b1;
              state_d = IGNORE;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              cnt_d   = 3'd0;
              oe_d    = 1'b0;
              state_d = RD_ACK;
            end else begin
              cnt_d = cnt_q + 3'd1;
              tx_d  = {tx_q[6:0], 1'b0};
              oe_d  = ~tx_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              pend_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = IGNORE;
            end
          end else if (scl_fall && pend_q) begin
            do_load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      // next read byte goes on the bus in the same cycle it is taken
      if (do_load) begin
        tx_d    = ld_byte;
        txr_d   = data_tx_valid_i;
        err_d   = ~data_tx_valid_i;
        oe_d    = ~ld_byte[7];
        cnt_d   = 3'd0;
        pend_d  = 1'b0;
        state_d = RD_DATA;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      sh_q     <= 8'h00;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
      rw_q     <= 1'b0;
      pend_q   <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      rxv_q    <= 1'b0;
      txr_q    <= 1'b0;
      match_q  <= 1'b0;
      stop_q   <= 1'b0;
      nack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rw_q     <= rw_d;
      pend_q   <= pend_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      rxv_q    <= rxv_d;
      txr_q    <= txr_d;
      match_q  <= match_d;
      stop_q   <= stop_d;
      nack_q   <= nack_d;
      err_q    <= err_d;
    end
  end

  assign sda_o           = 1'b0;
  assign sda_oe          = oe_q;
  assign data_rx_o       = rx_q;
  assign data_rx_valid_o = rxv_q;
  assign data_tx_ready_o = txr_q;
  assign busy_o          = busy_q;
  assign addr_match_o    = match_q;
  assign stop_o          = stop_q;
  assign nack_o          = nack_q;
  assign err_o           = err_q;

endmodule
